// File: rtl/alu_arb.sv
// alu_arb: round-robin arbiter sharing one combinational ALU between NREQ
// requesters, with a single tagged result register on the response side.
// Optional feature: define ALU_ARB_LOCK_EN to let the last-granted requester
// hold the grant across consecutive operations via its lock bit.
module alu_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [64*NREQ-1:0] req_a,
  input  logic [64*NREQ-1:0] req_b,
  input  logic [32*NREQ-1:0] req_ir,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [63:0]        rsp_data,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [63:0]        alu_a,
  output logic [63:0]        alu_b,
  output logic [31:0]        alu_ir,
  input  logic [63:0]        alu_out,
  input  logic [NREQ-1:0]    lock
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] nxt;
  logic [IDW-1:0] sel;
  logic           any_valid;
  logic           rsp_sel;
  logic           free;
  logic           accept;

`ifndef ALU_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  // Pick the first valid requester after ptr, optionally overridden by a held lock
  always_comb begin
    any_valid = 1'b0;
    win       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!any_valid && req_valid[i] && (((int'(ptr) + k) % NREQ) == i)) begin
          any_valid = 1'b1;
          win       = IDW'(i);
        end
      end
    end
`ifdef ALU_ARB_LOCK_EN
    for (int i = 0; i < NREQ; i++) begin
      if ((int'(ptr) == i) && lock[i] && req_valid[i]) begin
        win = IDW'(i);
      end
    end
`endif
  end

  // Idle ALU inputs follow requester ptr+1 so they stay stable and X-free
  always_comb begin
    nxt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (((int'(ptr) + 1) % NREQ) == i) begin
        nxt = IDW'(i);
      end
    end
    sel = any_valid ? win : nxt;
  end

  // Steer the selected requester's operands onto the shared ALU
  always_comb begin
    alu_a  = req_a[63:0];
    alu_b  = req_b[63:0];
    alu_ir = req_ir[31:0];
    for (int i = 0; i < NREQ; i++) begin
      if (int'(sel) == i) begin
        alu_a  = req_a[64*i +: 64];
        alu_b  = req_b[64*i +: 64];
        alu_ir = req_ir[32*i +: 32];
      end
    end
  end

  // The result register is free when empty or when its owner takes it this cycle
  always_comb begin
    rsp_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(rsp_id) == i) begin
        rsp_sel = rsp_ready[i];
      end
    end
    free = (state == EMPTY) || rsp_sel;
  end

  // One-hot accept to the winner, suppressed during reset or backpressure
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = !rst && free && any_valid && (int'(win) == i);
    end
    accept = |(req_valid & req_ready);
  end

  // Result register FSM: capture on accept, drain when the owner is ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      ptr       <= IDW'(NREQ - 1);
    end else if (accept) begin
      state     <= FULL;
      rsp_valid <= 1'b1;
      rsp_id    <= win;
      rsp_data  <= alu_out;
      ptr       <= win;
    end else if ((state == FULL) && rsp_sel) begin
      state     <= EMPTY;
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_arb.md
Name: alu_arb

Overview:
- Shares one combinational `alu` instance between NREQ requesters, e.g. the integer execute stage and the AMO/address-generation path.
- Arbitration is round-robin. Requests use a valid/ready handshake.
- The ALU result is captured in a single output register and returned to the winning requester with a tagged response.
- Sits between the issue logic and the ALU; it owns the ALU's a/b/ir inputs.

Parameters:
- NREQ, 2, number of requesters (2..4).
- IDW, 2, width of the requester index; must satisfy 2**IDW >= NREQ.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  64*NREQ  operand a, flattened; requester i uses bits [64*i+63:64*i].
- req_b  in  64*NREQ  operand b, flattened the same way.
- req_ir  in  32*NREQ  instruction word, flattened; requester i uses bits [32*i+31:32*i].
- rsp_valid  out  1  result register holds a valid result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_data  out  64  ALU result.
- rsp_ready  in  NREQ  per-requester response accept; only bit rsp_id is sampled.
- alu_a  out  64  to ALU input a.
- alu_b  out  64  to ALU input b.
- alu_ir  out  32  to ALU input ir.
- alu_out  in  64  from ALU output.
- lock  in  NREQ  hold grant; only used when ALU_ARB_LOCK_EN is defined, otherwise ignored.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - rsp_valid=0, rsp_id=0, rsp_data=0.
  - Round-robin pointer ptr=NREQ-1, so requester 0 wins first.
  - Any held result is discarded.
  - req_ready=0 while rst=1.
- State machine, two states:
  - EMPTY: result register free.
  - FULL: rsp_valid=1, waiting for rsp_ready[rsp_id].
- Register free condition: free = EMPTY, or (FULL and rsp_ready[rsp_id]).
- Grant selection (combinational):
  - Scan indices ptr+1, ptr+2, ... modulo NREQ.
  - The first index with req_valid set is the winner w.
  - req_ready = (1<<w) when free and any req_valid is set; otherwise 0.
  - req_ready must not depend on req_ready of other requesters; no combinational loop through rsp_ready except via free.
- ALU drive:
  - alu_a, alu_b, alu_ir are muxed from the winner's fields.
  - With no winner they carry requester ptr+1's fields; the values are don't-care but must be stable and X-free.
- Accept (req_valid[w] & req_ready[w] at a clk edge):
  - rsp_data <= alu_out, rsp_id <= w, rsp_valid <= 1, ptr <= w.
  - Latency: exactly 1 cycle from accept to rsp_valid.
- Drain without new accept (FULL, rsp_ready[rsp_id]=1, no request valid):
  - rsp_valid <= 0, state goes to EMPTY.
  - rsp_id and rsp_data keep their last values.
- Simultaneous drain and accept:
  - The new result replaces the old in the same edge; rsp_valid stays 1.
  - Full throughput: one op per cycle.
- Backpressure: FULL with rsp_ready[rsp_id]=0 holds everything stable and req_ready=0 for all requesters.
- Pointer update: ptr changes only on accept. An idle cycle never moves ptr.
- Fairness: with all requesters continuously valid and rsp_ready tied high, grants cycle 0,1,..,NREQ-1,0.
- Requester obligation: a requester may withdraw req_valid before acceptance; the arbiter tolerates it, with no hold requirement.
- Reset mid-operation: rst during FULL drops the result; no response is issued for it.

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- Defined:
  - If lock[ptr]=1 and req_valid[ptr]=1, requester ptr wins regardless of round-robin order.
  - Lock is honoured only for the last-granted requester; this supports multi-op AMO sequences.
  - If lock[ptr]=1 but req_valid[ptr]=0, normal round-robin applies.
- Not defined: the lock port exists but is ignored; pure round-robin.

Test Plan:
- Basic add: after reset, req0 valid, a=5, b=7, ir=0x00000013 (ADDI), rsp_ready=all 1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=12.
- Subtract: req1 alone, a=3, b=5, ir=0x40000033 (SUB) -> rsp_id=1, rsp_data=0xFFFFFFFFFFFFFFFE.
- Round-robin: both requesters valid for 4 cycles, rsp_ready high -> grant order 0,1,0,1; rsp_valid high on 4 consecutive cycles.
- Backpressure: FULL with rsp_ready[rsp_id]=0 for 3 cycles -> req_ready=0, rsp_data/rsp_id unchanged. Release -> new accept on the same edge as the drain, rsp_valid stays 1.
- Reset mid-op: assert rst while FULL -> next cycle rsp_valid=0, and the first grant after reset goes to requester 0.
- ALU_ARB_LOCK_EN: req0 granted with lock[0]=1, both requesters valid -> req0 granted 3 cycles in a row. Deassert lock[0] -> next grant goes to req1.
